matrix_mult_unit: RTL and testbench
===================================

Name: matrix_mult_unit

Overview:
- Downstream companion of matrix_ctrl. Implements the multiply-into-current-matrix operation: C = A × B.
- A is the current top-of-stack matrix, read from matrix_ctrl peek_out_0..3. B is streamed in as four 128-bit rows.
- Computes the 16 dot products sequentially through the external matrix_row_comp unit over a valid/rdy handshake.
- Writes C back to matrix_ctrl via write_in_0..3 / write_en.

Parameters:
- ELEM_W, 32, width of one IEEE-754 single element; a row is 4*ELEM_W.
- MAX_WAIT, 64, cycles dp_valid may stay high without dp_rdy before abort.

Ports:
- clk  in  1  system clock, rising edge.
- rst_n  in  1  asynchronous active-low reset.
- in_valid  in  1  B row beat valid.
- in_data  in  4*ELEM_W  B row; element 0 at [127:96], element 3 at [31:0].
- in_ready  out  1  block accepts a B beat.
- peek_in_0..3  in  4*ELEM_W each  A rows 0..3, from matrix_ctrl peek_out_0..3.
- dp_a  out  4*ELEM_W  row operand to matrix_row_comp.
- dp_b  out  4*ELEM_W  column operand to matrix_row_comp.
- dp_valid  out  1  operands valid.
- dp_result  in  ELEM_W  dot-product result.
- dp_rdy  in  1  dp_result valid for the presented operands.
- write_out_0..3  out  4*ELEM_W each  C rows, to matrix_ctrl write_in_0..3.
- write_en  out  1  one-cycle write strobe to matrix_ctrl.
- busy  out  1  high in any state other than S_LOAD.
- err  out  1  sticky dot-product timeout flag.

Behaviour:
- Reset (async, rst_n=0): state S_LOAD, beat count 0, element index k=0, wait counter 0, B/A/C registers 0.
  - Outputs at reset: in_ready=1, dp_valid=0, dp_a=dp_b=0, write_en=0, write_out_*=0, busy=0, err=0.
  - Reset mid-operation discards all progress; no write_en is produced.
- S_LOAD: in_ready=1. A beat is accepted on in_valid && in_ready and stored as B row[beat]; beat count increments.
  - Accepting beat 0 clears err.
  - Accepting beat 3 also snapshots peek_in_0..3 into A, resets beat count and k, and moves to S_ISSUE next cycle.
  - A is sampled only at that edge; later peek changes are ignored.
- S_ISSUE: in_ready=0, dp_valid=1.
  - Index mapping: i=k[3:2], j=k[1:0].
  - dp_a = A row i.
  - dp_b = column j of B = {B0[j], B1[j], B2[j], B3[j]}, element order as in in_data.
  - On dp_valid && dp_rdy, C[i][j] <= dp_result and k increments; the wait counter clears; operands update the following cycle.
  - dp_valid stays high between elements.
  - After capturing k=15, go to S_WRITE.
  - Wait counter increments each cycle dp_valid=1 && dp_rdy=0. When it reaches MAX_WAIT: set err=1, drop dp_valid, return to S_LOAD with no write_en; C is not written back.
- S_WRITE: one cycle. write_en=1 and write_out_r = C row r, held stable from this cycle until the next S_WRITE. Then return to S_LOAD.
- Latency with dp_rdy tied high: 4th beat accepted at edge T; captures at edges T+1..T+16; write_en high in cycle T+17; in_ready returns at T+18.
- Back-pressure: in_valid while busy is ignored; upstream holds data until in_ready.
- write_en is never asserted outside S_WRITE. Stack selection (matrix_mode) is owned by matrix_ctrl; it must not change while busy=1.
- Arithmetic is done entirely by the external unit; this block only routes operands and results, and performs no rounding or width change.

Test Plan:
- Reset mid-S_ISSUE (after 5 captures) -> all outputs at reset values; no write_en; next load of 4 beats proceeds normally from k=0.
- Identity multiply:
  - Stimulus: A = identity (peek row r has 3F800000 in element r, 0 elsewhere); B rows all 128'h3F800000400000004040000040800000; dp_rdy=1 via real matrix_row_comp.
  - Required: write_en pulses exactly once, 17 cycles after the 4th beat; write_out_0..3 equal B rows.
- Transpose routing:
  - Stimulus: same B.
  - Required: at k=0, dp_b = 128'h3F8000003F8000003F8000003F800000; at k=3, dp_b = 128'h40800000408000004080000040800000; dp_a at k=4 equals peek_in_1.
- Stalling unit:
  - Stimulus: dp_rdy asserted only every 3rd cycle.
  - Required: 16 captures, dp_valid continuous, write_en at T+49, results identical to the identity case.
- Timeout:
  - Stimulus: dp_rdy held 0.
  - Required: err=1 after 64 cycles in S_ISSUE, dp_valid=0, no write_en, in_ready=1; the next beat 0 clears err.
- Snapshot/back-pressure:
  - Stimulus: change peek_in_* and drive in_valid during busy.
  - Required: results use the A sampled at beat 3; no beats accepted until in_ready=1.

Source files
------------

// File: rtl/matrix_mult_unit.sv
// rtl/matrix_mult_unit.sv - C = A x B sequencer: snapshots A, streams in B, routes 16 dot products
// through an external unit, and writes C back to the matrix stack.
module matrix_mult_unit #(
  parameter int ELEM_W   = 32,
  parameter int MAX_WAIT = 64
) (
  input  logic                clk,
  input  logic                rst_n,
  input  logic                in_valid,
  input  logic [4*ELEM_W-1:0] in_data,
  output logic                in_ready,
  input  logic [4*ELEM_W-1:0] peek_in_0,
  input  logic [4*ELEM_W-1:0] peek_in_1,
  input  logic [4*ELEM_W-1:0] peek_in_2,
  input  logic [4*ELEM_W-1:0] peek_in_3,
  output logic [4*ELEM_W-1:0] dp_a,
  output logic [4*ELEM_W-1:0] dp_b,
  output logic                dp_valid,
  input  logic [ELEM_W-1:0]   dp_result,
  input  logic                dp_rdy,
  output logic [4*ELEM_W-1:0] write_out_0,
  output logic [4*ELEM_W-1:0] write_out_1,
  output logic [4*ELEM_W-1:0] write_out_2,
  output logic [4*ELEM_W-1:0] write_out_3,
  output logic                write_en,
  output logic                busy,
  output logic                err
);

  localparam int ROW_W  = 4 * ELEM_W;
  localparam int WAIT_W = $clog2(MAX_WAIT + 1);

  typedef enum logic [1:0] {S_LOAD, S_ISSUE, S_WRITE} state_t;

  state_t            state_q, state_d;
  logic [ROW_W-1:0]  b_q  [4];
  logic [ROW_W-1:0]  a_q  [4];
  logic [ROW_W-1:0]  wr_q [4];
  logic [ELEM_W-1:0] c_q  [16];
  logic [1:0]        beat_q;
  logic [3:0]        k_q;
  logic [WAIT_W-1:0] wait_q;
  logic              err_q;
  logic              accept, capture, timeout;
  logic [1:0]        row_i, col_j;
  logic [ROW_W-1:0]  col_b;

  assign row_i = k_q[3:2];
  assign col_j = k_q[1:0];

  // Column j of B gathered so that element 0 of the operand comes from B row 0.
  always_comb begin
    col_b = '0;
    for (int r = 0; r < 4; r++) begin
      col_b[ROW_W-1-r*ELEM_W -: ELEM_W] = b_q[r][ROW_W-1-int'(col_j)*ELEM_W -: ELEM_W];
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) state_q <= S_LOAD;
    else        state_q <= state_d;
  end

  always_comb begin
    state_d  = state_q;
    in_ready = 1'b0;
    dp_valid = 1'b0;
    write_en = 1'b0;
    accept   = 1'b0;
    capture  = 1'b0;
    timeout  = 1'b0;
    case (state_q)
      S_LOAD: begin
        in_ready = 1'b1;
        accept   = in_valid;
        if (in_valid && beat_q == 2'd3) state_d = S_ISSUE;
      end
      S_ISSUE: begin
        dp_valid = 1'b1;
        capture  = dp_rdy;
        timeout  = !dp_rdy && (wait_q == WAIT_W'(MAX_WAIT - 1));
        if (capture && k_q == 4'd15) state_d = S_WRITE;
        else if (timeout)            state_d = S_LOAD;
      end
      S_WRITE: begin
        write_en = 1'b1;
        state_d  = S_LOAD;
      end
      default: state_d = S_LOAD;
    endcase
  end

  assign dp_a        = dp_valid ? a_q[row_i] : '0;
  assign dp_b        = dp_valid ? col_b : '0;
  assign busy        = (state_q != S_LOAD);
  assign err         = err_q;
  assign write_out_0 = wr_q[0];
  assign write_out_1 = wr_q[1];
  assign write_out_2 = wr_q[2];
  assign write_out_3 = wr_q[3];

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      for (int r = 0; r < 4; r++) begin
        b_q[r]  <= '0;
        a_q[r]  <= '0;
        wr_q[r] <= '0;
      end
      for (int i = 0; i < 16; i++) c_q[i] <= '0;
      beat_q <= '0;
      k_q    <= '0;
      wait_q <= '0;
      err_q  <= 1'b0;
    end else begin
      if (accept) begin
        b_q[beat_q] <= in_data;
        beat_q      <= beat_q + 2'd1;
        if (beat_q == 2'd0) err_q <= 1'b0;
        if (beat_q == 2'd3) begin
          a_q[0] <= peek_in_0;
          a_q[1] <= peek_in_1;
          a_q[2] <= peek_in_2;
          a_q[3] <= peek_in_3;
          k_q    <= '0;
          wait_q <= '0;
        end
      end
      if (capture) begin
        c_q[k_q] <= dp_result;
        k_q      <= k_q + 4'd1;
        wait_q   <= '0;
        // Output rows are latched only on a completed matrix so an abort leaves them untouched.
        if (k_q == 4'd15) begin
          for (int r = 0; r < 4; r++) begin
            for (int e = 0; e < 4; e++) begin
              wr_q[r][ROW_W-1-e*ELEM_W -: ELEM_W] <= (4*r + e == 15) ? dp_result : c_q[4*r + e];
            end
          end
        end
      end else if (dp_valid) begin
        if (timeout) begin
          err_q  <= 1'b1;
          wait_q <= '0;
        end else begin
          wait_q <= wait_q + WAIT_W'(1);
        end
      end
    end
  end

endmodule

// File: tb/tb_matrix_mult_unit.sv
// tb/tb_matrix_mult_unit.sv - directed and randomized bench for matrix_mult_unit with a
// small-integer float dot-product stand-in and a matrix-arithmetic reference model.
module tb_matrix_mult_unit;

  logic         clk = 1'b0;
  logic         rst_n;
  logic         in_valid;
  logic [127:0] in_data;
  logic         in_ready;
  logic [127:0] peek_in_0, peek_in_1, peek_in_2, peek_in_3;
  logic [127:0] dp_a, dp_b;
  logic         dp_valid;
  logic [31:0]  dp_result;
  logic         dp_rdy;
  logic [127:0] write_out_0, write_out_1, write_out_2, write_out_3;
  logic         write_en, busy, err;

  int n_checks = 0;
  int n_fail   = 0;
  int rdy_mode = 1;
  int stall_cnt = 0;
  int cap_cnt  = 0;
  int a_m [4][4];
  int b_m [4][4];

  always #5 clk = ~clk;

  matrix_mult_unit #(.ELEM_W(32), .MAX_WAIT(64)) dut (
    .clk(clk), .rst_n(rst_n),
    .in_valid(in_valid), .in_data(in_data), .in_ready(in_ready),
    .peek_in_0(peek_in_0), .peek_in_1(peek_in_1), .peek_in_2(peek_in_2), .peek_in_3(peek_in_3),
    .dp_a(dp_a), .dp_b(dp_b), .dp_valid(dp_valid), .dp_result(dp_result), .dp_rdy(dp_rdy),
    .write_out_0(write_out_0), .write_out_1(write_out_1),
    .write_out_2(write_out_2), .write_out_3(write_out_3),
    .write_en(write_en), .busy(busy), .err(err)
  );

  function automatic int f2i(logic [31:0] f);
    int e;
    if (f[30:0] == 31'd0) return 0;
    e = int'(f[30:23]) - 127;
    if (e < 0 || e > 23) return 0;
    return int'({1'b1, f[22:0]} >> (23 - e));
  endfunction

  function automatic logic [31:0] i2f(int v);
    int p;
    logic [31:0] m;
    if (v <= 0) return 32'd0;
    p = 0;
    for (int b = 0; b < 31; b++) if (v[b]) p = b;
    m = 32'(v) << (23 - p);
    return {1'b0, 8'(127 + p), m[22:0]};
  endfunction

  function automatic logic [127:0] a_row(int r);
    return {i2f(a_m[r][0]), i2f(a_m[r][1]), i2f(a_m[r][2]), i2f(a_m[r][3])};
  endfunction

  function automatic logic [127:0] b_row(int r);
    return {i2f(b_m[r][0]), i2f(b_m[r][1]), i2f(b_m[r][2]), i2f(b_m[r][3])};
  endfunction

  function automatic logic [127:0] b_col(int j);
    return {i2f(b_m[0][j]), i2f(b_m[1][j]), i2f(b_m[2][j]), i2f(b_m[3][j])};
  endfunction

  function automatic logic [127:0] c_row(int i);
    logic [127:0] row;
    int s;
    for (int j = 0; j < 4; j++) begin
      s = 0;
      for (int k = 0; k < 4; k++) s += a_m[i][k] * b_m[k][j];
      row[127-32*j -: 32] = i2f(s);
    end
    return row;
  endfunction

  // Stand-in for the external dot-product unit: exact for small non-negative integer floats.
  always_comb begin
    dp_result = i2f(f2i(dp_a[127:96]) * f2i(dp_b[127:96]) + f2i(dp_a[95:64]) * f2i(dp_b[95:64])
                  + f2i(dp_a[63:32])  * f2i(dp_b[63:32])  + f2i(dp_a[31:0])  * f2i(dp_b[31:0]));
  end

  always @(negedge clk) begin
    case (rdy_mode)
      0: dp_rdy = 1'b0;
      1: dp_rdy = 1'b1;
      default: begin
        if (dp_valid) begin
          dp_rdy    = (stall_cnt == 2);
          stall_cnt = (stall_cnt == 2) ? 0 : stall_cnt + 1;
        end else begin
          dp_rdy    = 1'b0;
          stall_cnt = 0;
        end
      end
    endcase
  end

  always @(posedge clk) if (dp_valid && dp_rdy) cap_cnt++;

  task automatic chk(input string tag, input logic [127:0] obs, input logic [127:0] exp);
    n_checks++;
    assert (obs === exp) else begin
      n_fail++;
      $error("FAIL %s: observed %h expected %h", tag, obs, exp);
    end
  endtask

  task automatic set_identity_a();
    for (int r = 0; r < 4; r++) for (int c = 0; c < 4; c++) a_m[r][c] = (r == c) ? 1 : 0;
  endtask

  task automatic set_spec_b();
    for (int r = 0; r < 4; r++) for (int c = 0; c < 4; c++) b_m[r][c] = c + 1;
  endtask

  task automatic set_random_ab();
    for (int r = 0; r < 4; r++) for (int c = 0; c < 4; c++) begin
      a_m[r][c] = $urandom_range(0, 15);
      b_m[r][c] = $urandom_range(0, 15);
    end
  endtask

  // Presents A on peek and streams the four B rows; returns at T+1 after the 4th acceptance.
  task automatic load_op();
    int guard;
    peek_in_0 = a_row(0);
    peek_in_1 = a_row(1);
    peek_in_2 = a_row(2);
    peek_in_3 = a_row(3);
    for (int b = 0; b < 4; b++) begin
      in_data  = b_row(b);
      in_valid = 1'b1;
      guard    = 0;
      while (!in_ready && guard < 200) begin
        @(posedge clk); #1;
        guard++;
      end
      chk("beat_ready", 128'(in_ready), 128'd1);
      @(posedge clk); #1;
      if (b == 0) chk("err_clear_beat0", 128'(err), 128'd0);
    end
    in_valid = 1'b0;
  endtask

  task automatic run_op(input int exp_edge, input bit check_route);
    int we_edge, pulses, gaps, bp_bad;
    logic [127:0] wo [4];
    we_edge = -1; pulses = 0; gaps = 0; bp_bad = 0;
    cap_cnt = 0;
    for (int e = 0; e <= 200; e++) begin
      if (e > 0) begin @(posedge clk); #1; end
      if (check_route && e == 0) begin
        chk("route_dpb_k0", dp_b, b_col(0));
        chk("route_dpa_k0", dp_a, a_row(0));
      end
      if (check_route && e == 3) chk("route_dpb_k3", dp_b, b_col(3));
      if (check_route && e == 4) chk("route_dpa_k4", dp_a, a_row(1));
      if (busy && in_ready) bp_bad++;
      if (write_en) begin
        pulses++;
        if (we_edge < 0) begin
          we_edge = e;
          wo[0] = write_out_0; wo[1] = write_out_1; wo[2] = write_out_2; wo[3] = write_out_3;
        end
        in_valid = 1'b0;
      end else if (busy && !dp_valid) begin
        gaps++;
      end
      if (we_edge >= 0 && e >= we_edge + 2) break;
    end
    chk("write_en_time", 128'(we_edge), 128'(exp_edge));
    chk("write_en_pulses", 128'(pulses), 128'd1);
    chk("captures", 128'(cap_cnt), 128'd16);
    chk("dp_valid_gaps", 128'(gaps), 128'd0);
    chk("in_ready_while_busy", 128'(bp_bad), 128'd0);
    chk("in_ready_after", 128'(in_ready), 128'd1);
    for (int r = 0; r < 4; r++) chk($sformatf("c_row%0d", r), wo[r], c_row(r));
    chk("write_out_held", write_out_3, c_row(3));
  endtask

  initial begin
    int wen_cnt;
    rst_n = 1'b0; in_valid = 1'b0; in_data = '0; dp_rdy = 1'b0;
    peek_in_0 = '0; peek_in_1 = '0; peek_in_2 = '0; peek_in_3 = '0;
    repeat (3) @(posedge clk);
    #1;
    chk("rst_in_ready", 128'(in_ready), 128'd1);
    chk("rst_busy", 128'(busy), 128'd0);
    chk("rst_dp_valid", 128'(dp_valid), 128'd0);
    chk("rst_write_out0", write_out_0, 128'd0);
    @(negedge clk) rst_n = 1'b1;
    @(posedge clk); #1;

    // Identity multiply with operand routing checks.
    rdy_mode = 1;
    set_identity_a(); set_spec_b();
    load_op();
    run_op(16, 1'b1);
    chk("identity_row0_is_b", write_out_0, 128'h3F800000400000004040000040800000);

    // Same matrices through a unit that answers only every third cycle.
    rdy_mode = 2;
    load_op();
    run_op(48, 1'b0);

    // Random matrices, unit always ready.
    rdy_mode = 1;
    for (int n = 0; n < 3; n++) begin
      set_random_ab();
      load_op();
      run_op(16, 1'b1);
    end

    // Random matrices with a stalling unit.
    rdy_mode = 2;
    set_random_ab();
    load_op();
    run_op(48, 1'b0);

    // Timeout: unit never answers.
    rdy_mode = 0;
    set_random_ab();
    load_op();
    wen_cnt = 0;
    for (int e = 1; e <= 70; e++) begin
      @(posedge clk); #1;
      if (write_en) wen_cnt++;
      if (e == 63) begin
        chk("to_err_before", 128'(err), 128'd0);
        chk("to_busy_before", 128'(busy), 128'd1);
      end
      if (e == 64) begin
        chk("to_err", 128'(err), 128'd1);
        chk("to_dp_valid", 128'(dp_valid), 128'd0);
        chk("to_in_ready", 128'(in_ready), 128'd1);
      end
    end
    chk("to_no_write_en", 128'(wen_cnt), 128'd0);
    rdy_mode = 1;
    set_random_ab();
    load_op();
    run_op(16, 1'b1);

    // Snapshot and back-pressure: peek changes and in_valid held during busy.
    set_random_ab();
    load_op();
    peek_in_0 = {4{32'h41000000}}; peek_in_1 = {4{32'h41100000}};
    peek_in_2 = {4{32'h41200000}}; peek_in_3 = {4{32'h41300000}};
    in_data  = {$urandom, $urandom, $urandom, $urandom};
    in_valid = 1'b1;
    run_op(16, 1'b0);

    // Reset after 5 captures discards the operation.
    set_random_ab();
    load_op();
    repeat (5) @(posedge clk);
    #1;
    rst_n = 1'b0;
    #1;
    chk("mid_rst_in_ready", 128'(in_ready), 128'd1);
    chk("mid_rst_dp_valid", 128'(dp_valid), 128'd0);
    chk("mid_rst_dp_a", dp_a, 128'd0);
    chk("mid_rst_dp_b", dp_b, 128'd0);
    chk("mid_rst_write_en", 128'(write_en), 128'd0);
    chk("mid_rst_busy", 128'(busy), 128'd0);
    chk("mid_rst_err", 128'(err), 128'd0);
    chk("mid_rst_wo", write_out_0 | write_out_1 | write_out_2 | write_out_3, 128'd0);
    wen_cnt = 0;
    repeat (2) begin @(posedge clk); #1; if (write_en) wen_cnt++; end
    @(negedge clk) rst_n = 1'b1;
    repeat (20) begin @(posedge clk); #1; if (write_en) wen_cnt++; end
    chk("mid_rst_no_write_en", 128'(wen_cnt), 128'd0);
    set_random_ab();
    load_op();
    run_op(16, 1'b1);

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
